// File: rtl/usb_tx_ll.sv
// USB full-speed transmit link layer: SYNC, NRZI-encoded bit-stuffed data, EOP.
// Runs at 48 MHz with four clocks per 12 Mb/s line symbol.
module usb_tx_ll (
  input  logic clk,
  input  logic rst,
  input  logic ll_start,
  input  logic ll_bit,
  input  logic ll_last,
  output logic ll_ack,
  output logic ll_busy,
  output logic phy_tx_dp,
  output logic phy_tx_dn,
  output logic phy_tx_en
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SYNC    = 3'd1,
    DATA    = 3'd2,
    STUFF   = 3'd3,
    EOP_SE0 = 3'd4,
    EOP_J   = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] phase_q, phase_d;
  logic [2:0] cnt_q, cnt_d;
  logic [2:0] stuff_q, stuff_d;
  logic       last_q, last_d;
  logic       line_q, line_d;
  logic       ll_ack_q, ll_ack_d;
  logic       ll_busy_q, ll_busy_d;
  logic       tx_dp_q, tx_dp_d;
  logic       tx_dn_q, tx_dn_d;
  logic       tx_en_q, tx_en_d;
  logic       strobe_s;
  logic       take_bit_s;

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      phase_q   <= 2'd0;
      cnt_q     <= 3'd0;
      stuff_q   <= 3'd0;
      last_q    <= 1'b0;
      line_q    <= 1'b1;
      ll_ack_q  <= 1'b0;
      ll_busy_q <= 1'b0;
      tx_dp_q   <= 1'b1;
      tx_dn_q   <= 1'b0;
      tx_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      stuff_q   <= stuff_d;
      last_q    <= last_d;
      line_q    <= line_d;
      ll_ack_q  <= ll_ack_d;
      ll_busy_q <= ll_busy_d;
      tx_dp_q   <= tx_dp_d;
      tx_dn_q   <= tx_dn_d;
      tx_en_q   <= tx_en_d;
    end
  end

  assign strobe_s = (phase_q == 2'd3);

  // Next-state logic; line_q is the NRZI level, 1 = J and 0 = K
  always_comb begin
    state_d    = state_q;
    phase_d    = (state_q == IDLE) ? 2'd0 : phase_q + 2'd1;
    cnt_d      = cnt_q;
    stuff_d    = stuff_q;
    last_d     = last_q;
    line_d     = line_q;
    take_bit_s = 1'b0;
    case (state_q)
      IDLE: begin
        line_d = 1'b1;
        if (ll_start) begin
          state_d = SYNC;
          cnt_d   = 3'd0;
          stuff_d = 3'd0;
          last_d  = 1'b0;
          line_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      SYNC: begin
        if (strobe_s) begin
          if (cnt_q == 3'd7) begin
            take_bit_s = 1'b1;
          end else begin
            cnt_d  = cnt_q + 3'd1;
            // KJKJKJKK: even symbol slots and the final slot are K
            line_d = (cnt_q == 3'd6) ? 1'b0 : ~cnt_q[0];
          end
        end else begin
          state_d = SYNC;
        end
      end
      DATA: begin
        if (strobe_s) begin
          if (stuff_q == 3'd6) begin
            state_d = STUFF;
            stuff_d = 3'd0;
            line_d  = ~line_q;
          end else if (last_q) begin
            state_d = EOP_SE0;
            cnt_d   = 3'd0;
          end else begin
            take_bit_s = 1'b1;
          end
        end else begin
          state_d = DATA;
        end
      end
      STUFF: begin
        if (strobe_s) begin
          if (last_q) begin
            state_d = EOP_SE0;
            cnt_d   = 3'd0;
          end else begin
            take_bit_s = 1'b1;
          end
        end else begin
          state_d = STUFF;
        end
      end
      EOP_SE0: begin
        if (strobe_s) begin
          if (cnt_q == 3'd1) begin
            state_d = EOP_J;
            line_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end else begin
          state_d = EOP_SE0;
        end
      end
      EOP_J: begin
        line_d = 1'b1;
        if (strobe_s) begin
          state_d = IDLE;
        end else begin
          state_d = EOP_J;
        end
      end
      default: begin
        state_d = IDLE;
        line_d  = 1'b1;
      end
    endcase
    if (take_bit_s) begin
      state_d = DATA;
      last_d  = ll_last;
      line_d  = ll_bit ? line_q : ~line_q;
      // SYNC's closing KK counts as one carried '1'
      stuff_d = ll_bit ? (((state_q == SYNC) ? 3'd1 : stuff_q) + 3'd1) : 3'd0;
    end else begin
      last_d = last_d;
    end
  end

  // Output decode from next-state values so every output is a flop
  always_comb begin
    tx_en_d   = (state_d != IDLE);
    ll_busy_d = (state_d != IDLE);
    if (state_d == EOP_SE0) begin
      tx_dp_d = 1'b0;
      tx_dn_d = 1'b0;
    end else begin
      tx_dp_d = line_d;
      tx_dn_d = ~line_d;
    end
    ll_ack_d = (phase_d == 2'd3) &&
               (((state_d == SYNC) && (cnt_d == 3'd7)) ||
                ((state_d == DATA) && (stuff_d != 3'd6) && !last_d) ||
                ((state_d == STUFF) && !last_d));
  end

  assign ll_ack    = ll_ack_q;
  assign ll_busy   = ll_busy_q;
  assign phy_tx_dp = tx_dp_q;
  assign phy_tx_dn = tx_dn_q;
  assign phy_tx_en = tx_en_q;

endmodule

// File: tb/tb_usb_tx_ll.sv
// Scoreboard bench for usb_tx_ll: a symbol-level packet model feeds expected
// line states, ll_ack positions and enable lengths to a free-running monitor.
`timescale 1ns/1ps
module tb_usb_tx_ll;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ll_start = 1'b0;
  logic ll_bit = 1'b0;
  logic ll_last = 1'b0;
  logic ll_ack, ll_busy, phy_tx_dp, phy_tx_dn, phy_tx_en;

  usb_tx_ll dut (
    .clk(clk), .rst(rst), .ll_start(ll_start), .ll_bit(ll_bit), .ll_last(ll_last),
    .ll_ack(ll_ack), .ll_busy(ll_busy), .phy_tx_dp(phy_tx_dp), .phy_tx_dn(phy_tx_dn),
    .phy_tx_en(phy_tx_en)
  );

  always #10 clk = ~clk;

  localparam logic [1:0] SYM_J = 2'b10;
  localparam logic [1:0] SYM_K = 2'b01;
  localparam logic [1:0] SYM_SE0 = 2'b00;

  int checks = 0;
  int errors = 0;
  bit bit_q[$];
  bit lastf_q[$];
  logic [1:0] exp_sym[$];
  int exp_ack[$];
  int exp_len[$];
  bit mon_on = 1'b0;
  bit skip_len = 1'b0;
  bit gap_expect = 1'b0;
  int rises = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: build the symbol stream directly from the line-coding rules
  task automatic model_push(input bit b[$]);
    logic [1:0] syms[$];
    logic [1:0] lvl;
    int ones;
    for (int i = 0; i < 8; i++) syms.push_back((i % 2 == 0 || i == 7) ? SYM_K : SYM_J);
    lvl = SYM_K;
    ones = 1;
    for (int i = 0; i < b.size(); i++) begin
      exp_ack.push_back(4 * syms.size());
      if (b[i]) ones++;
      else begin
        lvl = (lvl == SYM_J) ? SYM_K : SYM_J;
        ones = 0;
      end
      syms.push_back(lvl);
      if (ones == 6) begin
        lvl = (lvl == SYM_J) ? SYM_K : SYM_J;
        syms.push_back(lvl);
        ones = 0;
      end
      bit_q.push_back(b[i]);
      lastf_q.push_back(i == b.size() - 1);
    end
    syms.push_back(SYM_SE0);
    syms.push_back(SYM_SE0);
    syms.push_back(SYM_J);
    foreach (syms[i]) repeat (4) exp_sym.push_back(syms[i]);
    exp_len.push_back(4 * syms.size());
  endtask

  // Monitor: compares every cycle against the scoreboard queues
  initial begin
    bit prev_en = 1'b0;
    int cyc = 0;
    int idle = 0;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (phy_tx_en) begin
          if (!prev_en) begin
            cyc = 1;
            rises++;
            if (gap_expect) begin
              chk("idle_gap", idle, 1);
              gap_expect = 1'b0;
            end
          end else cyc++;
          if (exp_sym.size() == 0) chk("unexpected_tx", cyc, 0);
          else chk("line", {phy_tx_dp, phy_tx_dn}, exp_sym.pop_front());
          chk("busy_tx", ll_busy, 1);
        end else begin
          if (prev_en) begin
            if (skip_len) begin
              exp_sym.delete();
              exp_ack.delete();
              exp_len.delete();
              skip_len = 1'b0;
            end else if (exp_len.size() == 0) chk("extra_packet", cyc, 0);
            else chk("en_len", cyc, exp_len.pop_front());
            idle = 0;
          end
          idle++;
          chk("idle_line", {phy_tx_dp, phy_tx_dn}, SYM_J);
          chk("idle_busy", ll_busy, 0);
        end
        if (ll_ack) begin
          if (!phy_tx_en || exp_ack.size() == 0) chk("spurious_ack", cyc, -1);
          else chk("ack_pos", cyc, exp_ack.pop_front());
        end
        prev_en = phy_tx_en;
      end
    end
  end

  // Upstream bit source: present the head bit, consume it on each ll_ack
  initial begin
    forever begin
      @(negedge clk);
      if (ll_ack && bit_q.size() > 0) begin
        @(posedge clk);
        #1;
        void'(bit_q.pop_front());
        void'(lastf_q.pop_front());
      end
      ll_bit = (bit_q.size() > 0) ? bit_q[0] : 1'b0;
      ll_last = (lastf_q.size() > 0) ? lastf_q[0] : 1'b0;
    end
  end

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ll_busy && n < 3000);
    if (n >= 3000) chk("busy_timeout", n, 0);
    @(negedge clk);
    chk("pending_pkts", exp_len.size(), 0);
    chk("pending_acks", exp_ack.size(), 0);
    chk("unconsumed_bits", bit_q.size(), 0);
  endtask

  task automatic send_pkt(input bit b[$]);
    model_push(b);
    @(negedge clk);
    ll_start = 1'b1;
    @(negedge clk);
    ll_start = 1'b0;
    wait_idle();
    repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  task automatic rand_bits(output bit b[$], input int n, input bit bias_ones);
    b.delete();
    for (int i = 0; i < n; i++)
      b.push_back(bias_ones ? ($urandom_range(0, 4) != 0) : 1'($urandom_range(0, 1)));
  endtask

  initial begin
    bit b[$];
    bit b2[$];
    int r0;
    int n;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    mon_on = 1'b1;
    repeat (100) @(negedge clk);

    b.delete(); repeat (8) b.push_back(1'b0);
    send_pkt(b);
    b.delete(); repeat (8) b.push_back(1'b1);
    send_pkt(b);
    b.delete(); repeat (5) b.push_back(1'b1);
    send_pkt(b);
    b.delete(); b.push_back(1'b0);
    send_pkt(b);
    for (int k = 0; k < 10; k++) begin
      rand_bits(b, $urandom_range(1, 24), k[0]);
      send_pkt(b);
    end

    // Abort mid-DATA; start during reset must be ignored
    rand_bits(b, 16, 1'b0);
    model_push(b);
    @(negedge clk); ll_start = 1'b1;
    @(negedge clk); ll_start = 1'b0;
    repeat (49) @(negedge clk);
    rst = 1'b1;
    ll_start = 1'b1;
    skip_len = 1'b1;
    @(negedge clk);
    chk("rst_en", phy_tx_en, 0);
    chk("rst_line", {phy_tx_dp, phy_tx_dn}, SYM_J);
    chk("rst_busy", ll_busy, 0);
    chk("rst_ack", ll_ack, 0);
    rst = 1'b0;
    ll_start = 1'b0;
    #1;
    bit_q.delete();
    lastf_q.delete();
    repeat (3) @(negedge clk);
    rand_bits(b, 12, 1'b1);
    send_pkt(b);

    // Back-to-back with ll_start held high
    rand_bits(b, 9, 1'b1);
    rand_bits(b2, 7, 1'b0);
    model_push(b);
    model_push(b2);
    r0 = rises;
    @(negedge clk);
    ll_start = 1'b1;
    n = 0;
    while (rises < r0 + 1 && n < 500) begin @(negedge clk); n++; end
    #1;
    gap_expect = 1'b1;
    n = 0;
    while (rises < r0 + 2 && n < 2000) begin @(negedge clk); n++; end
    chk("b2b_second_pkt", rises, r0 + 2);
    ll_start = 1'b0;
    wait_idle();
    repeat (20) @(negedge clk);
    chk("b2b_pkt_count", rises, r0 + 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
